work_cpkt_rcv: RTL and testbench

- Receiving end of the work-dispatch cell-packet stream: consumes the dispatcher's `out_vld`/`out_data` beats and drives its `out_rdy` and `flag_wrk_exit`.
- Reassembles each CELL_LEN-beat cell into one wide job word and buffers up to SLOT_NUM jobs.
- Presents jobs to the worker over a valid/ready handshake.
- Converts worker completion pulses into correctly spaced exit pulses, so the dispatcher's in-flight worker count decrements once per job.

---
 rtl/work_cpkt_rcv_if.sv | 25 ++
 rtl/work_cpkt_rcv.sv | 159 +++++++++++++++
 tb/tb_work_cpkt_rcv.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/work_cpkt_rcv_if.sv
// Cell-stream and job/completion handshake bundle between the dispatcher, the
// receiver and the worker.
interface work_cpkt_rcv_if #(
    parameter int DWID     = 256,
    parameter int CELL_LEN = 4
);
    logic                     in_vld;
    logic [DWID-1:0]          in_data;
    logic                     in_rdy;
    logic                     job_vld;
    logic [DWID*CELL_LEN-1:0] job_data;
    logic                     job_rdy;
    logic                     wrk_done;
    logic                     flag_wrk_exit;

    modport master (
        output in_vld, in_data, job_rdy, wrk_done,
        input  in_rdy, job_vld, job_data, flag_wrk_exit
    );

    modport slave (
        input  in_vld, in_data, job_rdy, wrk_done,
        output in_rdy, job_vld, job_data, flag_wrk_exit
    );
endinterface

// File: rtl/work_cpkt_rcv.sv
// Reassembles dispatcher beats into wide jobs, buffers them for the worker and
// turns worker completions into spaced exit pulses back to the dispatcher.
module work_cpkt_rcv #(
    parameter int DWID       = 256,
    parameter int CELL_LEN   = 4,
    parameter int SLOT_NUM   = 4,
    parameter int RDY_MARGIN = 2,
    parameter int PEND_WID   = 8
) (
    input  logic                clk,
    input  logic                rst,
    work_cpkt_rcv_if.slave      bus,
    output logic [31:0]         cnt_ovf,
    output logic [31:0]         cnt_done_err,
    output logic [PEND_WID-1:0] cnt_pend_max
);
    localparam int BW = (CELL_LEN > 1) ? $clog2(CELL_LEN) : 1;
    localparam int SW = $clog2(SLOT_NUM);
    localparam int JW = DWID * CELL_LEN;
    localparam logic [BW-1:0]       LAST_BEAT = BW'(CELL_LEN - 1);
    localparam logic [SW:0]         PTR_FULL  = (SW + 1)'(SLOT_NUM);
    localparam logic [PEND_WID-1:0] CNT_MAX   = {PEND_WID{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } exit_st_e;

    logic [BW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                drop_q, drop_d;
    logic [SW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [JW-1:0]       slot_q [SLOT_NUM];
    logic [JW-1:0]       slot_d [SLOT_NUM];
    logic                in_rdy_q, in_rdy_d;
    logic                job_vld_q, job_vld_d;
    logic [JW-1:0]       job_data_q, job_data_d;
    logic [PEND_WID-1:0] outst_q, outst_d, pend_q, pend_d, pend_max_q, pend_max_d;
    logic [31:0]         ovf_q, ovf_d, derr_q, derr_d;
    exit_st_e            st_q, st_d;
    logic                flag_q, flag_d;

    logic [SW:0]         used_s, used_d;
    logic                drop_cur_s, last_s, pop_s, done_ok_s, dec_s, cip_s;
    logic [PEND_WID-1:0] peak_s;

    // Next-state logic for framing, slot buffer, credit, job output and exit FSM.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        slot_d     = slot_q;
        ovf_d      = ovf_q;
        derr_d     = derr_q;
        outst_d    = outst_q;
        pend_d     = pend_q;
        st_d       = st_q;
        dec_s      = 1'b0;

        used_s     = wr_ptr_q - rd_ptr_q;
        last_s     = (beat_cnt_q == LAST_BEAT);
        // The drop decision is latched at beat 0 and held for the rest of the cell.
        drop_cur_s = (beat_cnt_q == {BW{1'b0}}) ? (used_s == PTR_FULL) : drop_q;
        pop_s      = job_vld_q & bus.job_rdy;

        if (bus.in_vld) begin
            beat_cnt_d = last_s ? {BW{1'b0}} : beat_cnt_q + BW'(1);
            drop_d     = last_s ? 1'b0 : drop_cur_s;
            if (!drop_cur_s) begin
                slot_d[wr_ptr_q[SW-1:0]][int'(beat_cnt_q)*DWID +: DWID] = bus.in_data;
                wr_ptr_d = last_s ? wr_ptr_q + (SW + 1)'(1) : wr_ptr_q;
            end else begin
                ovf_d = last_s ? ovf_q + 32'd1 : ovf_q;
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end

        rd_ptr_d   = pop_s ? rd_ptr_q + (SW + 1)'(1) : rd_ptr_q;
        used_d     = wr_ptr_d - rd_ptr_d;
        cip_s      = (beat_cnt_d != {BW{1'b0}}) & ~drop_d;
        in_rdy_d   = (int'(SLOT_NUM) - int'(used_d) - int'(cip_s)) >= RDY_MARGIN;
        job_vld_d  = (used_d != {(SW + 1){1'b0}});
        job_data_d = slot_d[rd_ptr_d[SW-1:0]];

        done_ok_s = bus.wrk_done & ((outst_q != {PEND_WID{1'b0}}) | pop_s);
        derr_d    = (bus.wrk_done & ~done_ok_s) ? derr_q + 32'd1 : derr_q;
        case ({pop_s, done_ok_s})
            2'b10:   outst_d = (outst_q != CNT_MAX) ? outst_q + PEND_WID'(1) : outst_q;
            2'b01:   outst_d = outst_q - PEND_WID'(1);
            default: outst_d = outst_q;
        endcase

        case (st_q)
            S_IDLE:  st_d = (pend_q != {PEND_WID{1'b0}}) ? S_PULSE : S_IDLE;
            S_PULSE: begin
                dec_s = 1'b1;
                st_d  = S_GAP;
            end
            S_GAP:   st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
        flag_d = (st_d == S_PULSE);

        case ({done_ok_s, dec_s})
            2'b10:   pend_d = (pend_q != CNT_MAX) ? pend_q + PEND_WID'(1) : pend_q;
            2'b01:   pend_d = pend_q - PEND_WID'(1);
            default: pend_d = pend_q;
        endcase
        // The exit being pulsed this cycle still counts as owed for the peak.
        peak_s     = (done_ok_s && pend_q != CNT_MAX) ? pend_q + PEND_WID'(1) : pend_q;
        pend_max_d = (peak_s > pend_max_q) ? peak_s : pend_max_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= {BW{1'b0}};
            drop_q     <= 1'b0;
            wr_ptr_q   <= {(SW + 1){1'b0}};
            rd_ptr_q   <= {(SW + 1){1'b0}};
            for (int i = 0; i < SLOT_NUM; i++) slot_q[i] <= {JW{1'b0}};
            in_rdy_q   <= 1'b0;
            job_vld_q  <= 1'b0;
            job_data_q <= {JW{1'b0}};
            outst_q    <= {PEND_WID{1'b0}};
            pend_q     <= {PEND_WID{1'b0}};
            pend_max_q <= {PEND_WID{1'b0}};
            ovf_q      <= 32'd0;
            derr_q     <= 32'd0;
            st_q       <= S_IDLE;
            flag_q     <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < SLOT_NUM; i++) slot_q[i] <= slot_d[i];
            in_rdy_q   <= in_rdy_d;
            job_vld_q  <= job_vld_d;
            job_data_q <= job_data_d;
            outst_q    <= outst_d;
            pend_q     <= pend_d;
            pend_max_q <= pend_max_d;
            ovf_q      <= ovf_d;
            derr_q     <= derr_d;
            st_q       <= st_d;
            flag_q     <= flag_d;
        end
    end

    assign bus.in_rdy        = in_rdy_q;
    assign bus.job_vld       = job_vld_q;
    assign bus.job_data      = job_data_q;
    assign bus.flag_wrk_exit = flag_q;
    assign cnt_ovf           = ovf_q;
    assign cnt_done_err      = derr_q;
    assign cnt_pend_max      = pend_max_q;
endmodule

// File: tb/tb_work_cpkt_rcv.sv
// Directed bench for work_cpkt_rcv: framing, buffering, overflow, credit,
// exit pulse spacing and mid-cell reset.
module tb_work_cpkt_rcv;
    localparam int DWID       = 256;
    localparam int CELL_LEN   = 4;
    localparam int SLOT_NUM   = 4;
    localparam int RDY_MARGIN = 2;
    localparam int PEND_WID   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         cnt_ovf;
    logic [31:0]         cnt_done_err;
    logic [PEND_WID-1:0] cnt_pend_max;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int pulses;
    int adj;
    logic prev_flag;
    bit exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    work_cpkt_rcv_if #(.DWID(DWID), .CELL_LEN(CELL_LEN)) bus ();

    work_cpkt_rcv #(
        .DWID(DWID), .CELL_LEN(CELL_LEN), .SLOT_NUM(SLOT_NUM),
        .RDY_MARGIN(RDY_MARGIN), .PEND_WID(PEND_WID)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .cnt_ovf(cnt_ovf),
        .cnt_done_err(cnt_done_err),
        .cnt_pend_max(cnt_pend_max)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DWID-1:0] obs, input logic [DWID-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_job(input string tag, input int base);
        for (int k = 0; k < CELL_LEN; k++)
            chk(tag, bus.job_data[k*DWID +: DWID], DWID'(base + k));
    endtask

    // Drives one cell; optionally raises job_rdy with the last beat and checks
    // that job_vld is still low before the last beat lands.
    task automatic send_cell(input int base, input bit rdy_last, input bit chk_lat);
        for (int k = 0; k < CELL_LEN; k++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = DWID'(base + k);
            if (k == CELL_LEN - 1 && rdy_last) bus.job_rdy = 1'b1;
            tick();
            if (k == CELL_LEN - 2 && chk_lat) chk("lat_before_last", DWID'(bus.job_vld), DWID'(0));
        end
        bus.in_vld = 1'b0;
        if (rdy_last) bus.job_rdy = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_vld   = 1'b0;
        bus.in_data  = '0;
        bus.job_rdy  = 1'b0;
        bus.wrk_done = 1'b0;
        tick(); tick(); tick();
        chk("rst_in_rdy", DWID'(bus.in_rdy), DWID'(0));
        chk("rst_job_vld", DWID'(bus.job_vld), DWID'(0));
        chk("rst_flag", DWID'(bus.flag_wrk_exit), DWID'(0));
        chk("rst_ovf", DWID'(cnt_ovf), DWID'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_in_rdy", DWID'(bus.in_rdy), DWID'(1));

        // Three cells streamed with the worker always ready.
        bus.job_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            send_cell(16 + 4*c, 1'b0, 1'b1);
            chk("t1_job_vld", DWID'(bus.job_vld), DWID'(1));
            chk_job("t1_job_data", 16 + 4*c);
        end
        tick();
        chk("t1_empty", DWID'(bus.job_vld), DWID'(0));
        chk("t1_ovf", DWID'(cnt_ovf), DWID'(0));
        chk("t1_in_rdy", DWID'(bus.in_rdy), DWID'(1));
        bus.job_rdy = 1'b0;

        // Three consecutive completions against three outstanding jobs.
        pulses = 0; adj = 0; prev_flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.wrk_done = (i < 3);
            tick();
            if (bus.flag_wrk_exit) begin
                pulses++;
                if (prev_flag) adj++;
            end
            prev_flag = bus.flag_wrk_exit;
        end
        bus.wrk_done = 1'b0;
        chk("t3_pulses", DWID'(pulses), DWID'(3));
        chk("t3_adjacent", DWID'(adj), DWID'(0));
        chk("t3_pend_max", DWID'(cnt_pend_max), DWID'(3));
        chk("t3_done_err", DWID'(cnt_done_err), DWID'(0));

        // Completion with nothing outstanding.
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            bus.wrk_done = (i == 0);
            tick();
            if (bus.flag_wrk_exit) pulses++;
        end
        chk("t4_pulses", DWID'(pulses), DWID'(0));
        chk("t4_done_err", DWID'(cnt_done_err), DWID'(1));

        // Five cells into four slots with the worker stalled.
        for (int c = 0; c < 5; c++) begin
            send_cell(32 + 4*c, 1'b0, 1'b0);
            chk("t2_in_rdy", DWID'(bus.in_rdy), DWID'(exp_rdy[c]));
            chk("t2_ovf", DWID'(cnt_ovf), DWID'((c == 4) ? 1 : 0));
            chk("t2_held_vld", DWID'(bus.job_vld), DWID'(1));
            chk("t2_held_lane0", bus.job_data[DWID-1:0], DWID'(32));
        end
        bus.job_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("t2_pop_vld", DWID'(bus.job_vld), DWID'(1));
            chk_job("t2_pop_data", 32 + 4*c);
            tick();
        end
        chk("t2_drained", DWID'(bus.job_vld), DWID'(0));
        chk("t2_in_rdy_after", DWID'(bus.in_rdy), DWID'(1));
        bus.job_rdy = 1'b0;

        // Commit and pop on the same edge with three slots used.
        for (int c = 0; c < 3; c++) send_cell(64 + 4*c, 1'b0, 1'b0);
        chk("t6_in_rdy_3used", DWID'(bus.in_rdy), DWID'(0));
        send_cell(76, 1'b1, 1'b0);
        chk("t6_in_rdy_same", DWID'(bus.in_rdy), DWID'(0));
        chk("t6_ovf", DWID'(cnt_ovf), DWID'(1));
        chk("t6_vld", DWID'(bus.job_vld), DWID'(1));
        chk_job("t6_head", 68);
        bus.job_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("t6_pop_vld", DWID'(bus.job_vld), DWID'(1));
            chk_job("t6_pop_data", 68 + 4*c);
            tick();
        end
        chk("t6_drained", DWID'(bus.job_vld), DWID'(0));
        chk("t6_in_rdy_after", DWID'(bus.in_rdy), DWID'(1));
        bus.job_rdy = 1'b0;

        // Reset after three beats of a cell, then a fresh cell.
        for (int k = 0; k < 3; k++) begin
            bus.in_vld  = 1'b1;
            bus.in_data = DWID'(96 + k);
            tick();
        end
        bus.in_vld = 1'b0;
        rst = 1'b1;
        tick(); tick();
        chk("t5_rst_in_rdy", DWID'(bus.in_rdy), DWID'(0));
        chk("t5_rst_vld", DWID'(bus.job_vld), DWID'(0));
        chk("t5_rst_data", bus.job_data[DWID-1:0], DWID'(0));
        chk("t5_rst_ovf", DWID'(cnt_ovf), DWID'(0));
        chk("t5_rst_derr", DWID'(cnt_done_err), DWID'(0));
        chk("t5_rst_pmax", DWID'(cnt_pend_max), DWID'(0));
        rst = 1'b0;
        tick();
        chk("t5_in_rdy", DWID'(bus.in_rdy), DWID'(1));
        send_cell(112, 1'b0, 1'b1);
        chk("t5_vld", DWID'(bus.job_vld), DWID'(1));
        chk_job("t5_data", 112);
        chk("t5_in_rdy_1used", DWID'(bus.in_rdy), DWID'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
